ifetch_pcgen: RTL

Next-PC generator for instruction fetch. It sits directly upstream of the icache and drives the `coretoic_pc_valid` / `coretoic_pc_retry` / `coretoic_pc` request channel. It produces sequential fetch addresses, takes redirects from the core, and limits outstanding icache requests with a credit counter. After a redirect it tells the consumer of `ictocore` which stale responses to discard.

---
 rtl/ifetch_pcgen_pkg.sv | 20 ++
 rtl/ifetch_credit.sv | 69 ++++++
 rtl/ifetch_pcgen.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ifetch_pcgen_pkg.sv
// Shared defaults and types for the instruction-fetch next-PC generator.
package ifetch_pcgen_pkg;

  localparam int unsigned IFETCH_FETCH_BYTES  = 16;
  localparam int unsigned IFETCH_MAX_INFLIGHT = 4;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_CREDIT_WAIT = 2'd1,
    ST_DRAIN       = 2'd2
  } I_ifetch_state_type;

  typedef struct packed {
    logic [31:0] redirects;
    logic [31:0] credit_stall;
    logic [31:0] retry_stall;
    logic [31:0] killed;
  } I_ifetch_perf_type;

endpackage

// File: rtl/ifetch_credit.sv
// Outstanding icache request counter plus stale-response drop counter.
module ifetch_credit
  import ifetch_pcgen_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = IFETCH_MAX_INFLIGHT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_xfer,
  input  logic       i_done,
  input  logic       i_redirect,
  output logic [3:0] o_inflight,
  output logic [3:0] o_inflight_nxt,
  output logic       o_kill,
  output logic       o_full,
  output logic       o_drain_nxt
);

  logic [3:0] r_inflight;
  logic [3:0] r_drop;
  logic [3:0] w_inflight_nxt;
  logic [3:0] w_drop_nxt;
  logic       w_kill;

  assign w_kill = !reset && i_done && (r_drop != '0);

  always_comb begin
    w_inflight_nxt = r_inflight;
    if (i_xfer && !i_done) begin
      w_inflight_nxt = r_inflight + 4'd1;
    end else if (!i_xfer && i_done && (r_inflight != '0)) begin
      w_inflight_nxt = r_inflight - 4'd1;
    end
  end

  // A redirect reloads with the post-update count, which already covers
  // any older stale requests still being drained.
  always_comb begin
    w_drop_nxt = r_drop;
    if (i_redirect) begin
      w_drop_nxt = w_inflight_nxt;
    end else if (w_kill) begin
      w_drop_nxt = r_drop - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(i_done && (r_inflight == '0)));
    end
  end

  assign o_inflight     = r_inflight;
  assign o_inflight_nxt = w_inflight_nxt;
  assign o_kill         = w_kill;
  assign o_full         = (r_inflight >= 4'(MAX_INFLIGHT));
  assign o_drain_nxt    = (w_drop_nxt != '0);

endmodule

// File: rtl/ifetch_pcgen.sv
// Next-PC generator feeding the icache request channel.
// Optional perf counters enabled by defining IFETCH_PCGEN_PERF_EN.
module ifetch_pcgen
  import ifetch_pcgen_pkg::*;
#(
  parameter int unsigned          PC_WIDTH     = 64,
  parameter int unsigned          FETCH_BYTES  = IFETCH_FETCH_BYTES,
  parameter int unsigned          MAX_INFLIGHT = IFETCH_MAX_INFLIGHT,
  parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                coretoic_pc_valid,
  input  logic                coretoic_pc_retry,
  output logic [PC_WIDTH-1:0] coretoic_pc,
  input  logic                ic_resp_done,
  output logic                ic_resp_kill,
  output logic [3:0]          inflight
`ifdef IFETCH_PCGEN_PERF_EN
  ,
  output logic [31:0]         perf_redirects,
  output logic [31:0]         perf_credit_stall,
  output logic [31:0]         perf_retry_stall,
  output logic [31:0]         perf_killed
`endif
);

  localparam logic [PC_WIDTH-1:0] LP_STEP  = PC_WIDTH'(FETCH_BYTES);
  localparam logic [PC_WIDTH-1:0] LP_ALIGN = ~(PC_WIDTH'(FETCH_BYTES - 1));
  localparam logic [PC_WIDTH-1:0] LP_EVEN  = ~(PC_WIDTH'(1));

  logic [PC_WIDTH-1:0] r_pc;
  I_ifetch_state_type  r_state;
  logic                w_valid;
  logic                w_xfer;
  logic                w_full;
  logic                w_kill;
  logic                w_drain_nxt;
  logic [3:0]          w_inflight;
  logic [3:0]          w_inflight_nxt;

  ifetch_credit #(
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_credit (
    .clk            (clk),
    .reset          (reset),
    .i_xfer         (w_xfer),
    .i_done         (ic_resp_done),
    .i_redirect     (redirect_valid),
    .o_inflight     (w_inflight),
    .o_inflight_nxt (w_inflight_nxt),
    .o_kill         (w_kill),
    .o_full         (w_full),
    .o_drain_nxt    (w_drain_nxt)
  );

  assign w_valid = !reset && !w_full;
  assign w_xfer  = w_valid && !coretoic_pc_retry;

  // Redirect wins over a same-cycle transfer: the request still counts as
  // in flight, but its sequential advance is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc & LP_EVEN;
    end else if (w_xfer) begin
      r_pc <= (r_pc & LP_ALIGN) + LP_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else if (w_inflight_nxt == 4'(MAX_INFLIGHT)) begin
      r_state <= ST_CREDIT_WAIT;
    end else if (w_drain_nxt) begin
      r_state <= ST_DRAIN;
    end else begin
      r_state <= ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ((r_state == ST_CREDIT_WAIT) == !w_valid);
    end
  end

  assign coretoic_pc_valid = w_valid;
  assign coretoic_pc       = r_pc;
  assign ic_resp_kill      = w_kill;
  assign inflight          = w_inflight;

`ifdef IFETCH_PCGEN_PERF_EN
  I_ifetch_perf_type r_perf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf <= '0;
    end else begin
      if (redirect_valid && (r_perf.redirects != '1))
        r_perf.redirects <= r_perf.redirects + 32'd1;
      if ((r_state == ST_CREDIT_WAIT) && (r_perf.credit_stall != '1))
        r_perf.credit_stall <= r_perf.credit_stall + 32'd1;
      if (w_valid && coretoic_pc_retry && (r_perf.retry_stall != '1))
        r_perf.retry_stall <= r_perf.retry_stall + 32'd1;
      if (w_kill && (r_perf.killed != '1))
        r_perf.killed <= r_perf.killed + 32'd1;
    end
  end

  assign perf_redirects    = r_perf.redirects;
  assign perf_credit_stall = r_perf.credit_stall;
  assign perf_retry_stall  = r_perf.retry_stall;
  assign perf_killed       = r_perf.killed;
`endif

endmodule
